// File: rtl/sort_chunk_feeder_pkg.sv
// rtl/sort_chunk_feeder_pkg.sv - shared types, defaults and slot helper for the sort chunk feeder
package sort_chunk_feeder_pkg;

    localparam int TUPLE_W       = 128;
    localparam int DEFAULT_LANES = 2;
    localparam int DEFAULT_CHUNK = 16;

    typedef logic [TUPLE_W-1:0] tuple_pair_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } feeder_state_t;

    // LSB position of slot k inside a flat block of w-bit tuples
    function automatic int slot_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/sort_chunk_feeder_pack_reg.sv
// rtl/sort_chunk_feeder_pack_reg.sv - CHUNK-slot block register with row writes, clear, mask and optional padding (FEEDER_PAD_EN)
module sort_chunk_feeder_pack_reg
    import sort_chunk_feeder_pkg::*;
#(
    parameter int TUPLE_W = sort_chunk_feeder_pkg::TUPLE_W,
    parameter int LANES   = DEFAULT_LANES,
    parameter int CHUNK   = DEFAULT_CHUNK,
    parameter int ROW_W   = 3
)
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear_in,
    input  logic                       wr_en_in,
    input  logic [ROW_W-1:0]           wr_row_in,
    input  logic [LANES*TUPLE_W-1:0]   row_data_in,
    input  logic [LANES-1:0]           lane_valid_in,
    output logic [CHUNK*TUPLE_W-1:0]   flat_out,
    output logic [CHUNK-1:0]           mask_out
);

    // Value held by any slot that does not carry a real tuple
`ifdef FEEDER_PAD_EN
    localparam logic [TUPLE_W-1:0] FILL_VAL = '1;
`else
    localparam logic [TUPLE_W-1:0] FILL_VAL = '0;
`endif

    for (genvar s = 0; s < CHUNK; s++) begin : g_slot
        localparam int ROW  = s / LANES;
        localparam int LANE = s % LANES;
        localparam int LSB  = slot_lsb(s, TUPLE_W);

        logic [TUPLE_W-1:0] slot_d, slot_q;
        logic               mask_d, mask_q;

        // Slot update: clear to the fill value, or take its lane when its row is captured
        always_comb begin
            slot_d = slot_q;
            mask_d = mask_q;
            if (clear_in) begin
                slot_d = FILL_VAL;
                mask_d = 1'b0;
            end else if (wr_en_in && (wr_row_in == ROW_W'(ROW))) begin
                slot_d = lane_valid_in[LANE] ? row_data_in[LANE*TUPLE_W +: TUPLE_W] : FILL_VAL;
                mask_d = lane_valid_in[LANE];
            end
        end

        // Slot storage; reset leaves the block all-zero with an empty mask
        always_ff @(posedge clock) begin
            if (reset) begin
                slot_q <= '0;
                mask_q <= 1'b0;
            end else begin
                slot_q <= slot_d;
                mask_q <= mask_d;
            end
        end

        assign flat_out[LSB +: TUPLE_W] = slot_q;
        assign mask_out[s]              = mask_q;
    end

endmodule

// File: rtl/sort_chunk_feeder.sv
// rtl/sort_chunk_feeder.sv - streams banked-memory rows into CHUNK-wide blocks for the bitonic sorter (FEEDER_PAD_EN pads empty slots)
module sort_chunk_feeder
    import sort_chunk_feeder_pkg::*;
#(
    parameter int TUPLE_W = sort_chunk_feeder_pkg::TUPLE_W,
    parameter int LANES   = DEFAULT_LANES,
    parameter int CHUNK   = DEFAULT_CHUNK,
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 16
)
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start_in,
    input  logic [LEN_W-1:0]          length_in,
    output logic                      mem_read_en_out,
    output logic [ADDR_W-1:0]         mem_addr_out,
    input  logic [LANES*TUPLE_W-1:0]  mem_data_in,
    output logic                      chunk_valid_out,
    input  logic                      chunk_ready_in,
    output logic [CHUNK*TUPLE_W-1:0]  chunk_flat_out,
    output logic [CHUNK-1:0]          chunk_mask_out,
    output logic                      chunk_last_out,
    output logic                      busy_out,
    output logic                      done_out
);

    localparam int R     = CHUNK / LANES;
    localparam int LOG_L = $clog2(LANES);
    localparam int ROW_W = (R > 1) ? $clog2(R) : 1;
    localparam int RD_W  = $clog2(R) + 1;
    localparam int CNT_W = LEN_W + 1;

    feeder_state_t     state_q, state_d;
    logic [LEN_W-1:0]  length_q, length_d;
    logic [CNT_W-1:0]  rows_total_q, rows_total_d;
    logic [CNT_W-1:0]  rows_issued_q, rows_issued_d;
    logic [CNT_W-1:0]  cap_row_q, cap_row_d;
    logic [RD_W-1:0]   reads_blk_q, reads_blk_d;
    logic [ROW_W-1:0]  cap_slot_q, cap_slot_d;
    logic              cap_pending_q, cap_pending_d;
    logic              done_q, done_d;

    logic              start_go;
    logic              rows_left;
    logic [CNT_W-1:0]  rows_calc;
    logic [CNT_W-1:0]  row_base;
    logic [LANES-1:0]  lane_valid;
    logic              read_en;
    logic              valid;
    logic              last;
    logic              busy;
    logic              transfer;
    logic              clear_blk;

    assign start_go  = (state_q == IDLE) && start_in && (length_in != '0);
    assign rows_left = rows_issued_q < rows_total_q;
    assign rows_calc = ({1'b0, length_in} + CNT_W'(LANES - 1)) >> LOG_L;

    // Global tuple index of each lane in the row being captured, checked against the pass length
    assign row_base = cap_row_q << LOG_L;
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_valid[l] = (row_base + CNT_W'(l)) < {1'b0, length_q};
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fill until the last issued row is captured, hold until the sorter takes the block
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_go) state_d = FILL;
            FILL: if (cap_pending_q && !read_en) state_d = HOLD;
            HOLD: if (transfer) state_d = rows_left ? FILL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs; reads only in FILL so backpressure never strands returning data
    always_comb begin
        read_en   = 1'b0;
        valid     = 1'b0;
        last      = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: busy = 1'b0;
            FILL: read_en = (reads_blk_q < RD_W'(R)) && rows_left;
            HOLD: begin
                valid = 1'b1;
                last  = (rows_issued_q == rows_total_q);
            end
            default: busy = 1'b0;
        endcase
        transfer  = valid && chunk_ready_in;
        clear_blk = start_go || (transfer && rows_left);
    end

    // Counters, capture bookkeeping and the done pulse
    always_comb begin
        length_d      = length_q;
        rows_total_d  = rows_total_q;
        rows_issued_d = rows_issued_q;
        reads_blk_d   = reads_blk_q;
        cap_row_d     = cap_row_q;
        cap_slot_d    = cap_slot_q;
        cap_pending_d = read_en;
        done_d        = ((state_q == IDLE) && start_in && (length_in == '0)) ||
                        (transfer && !rows_left);
        if (start_go) begin
            length_d      = length_in;
            rows_total_d  = rows_calc;
            rows_issued_d = '0;
            reads_blk_d   = '0;
        end
        if (read_en) begin
            rows_issued_d = rows_issued_q + CNT_W'(1);
            reads_blk_d   = reads_blk_q + RD_W'(1);
            cap_row_d     = rows_issued_q;
            cap_slot_d    = reads_blk_q[ROW_W-1:0];
        end
        if (transfer) begin
            reads_blk_d = '0;
        end
    end

    // Datapath registers; reset drops any capture still in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            length_q      <= '0;
            rows_total_q  <= '0;
            rows_issued_q <= '0;
            reads_blk_q   <= '0;
            cap_row_q     <= '0;
            cap_slot_q    <= '0;
            cap_pending_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            length_q      <= length_d;
            rows_total_q  <= rows_total_d;
            rows_issued_q <= rows_issued_d;
            reads_blk_q   <= reads_blk_d;
            cap_row_q     <= cap_row_d;
            cap_slot_q    <= cap_slot_d;
            cap_pending_q <= cap_pending_d;
            done_q        <= done_d;
        end
    end

    sort_chunk_feeder_pack_reg #(
        .TUPLE_W (TUPLE_W),
        .LANES   (LANES),
        .CHUNK   (CHUNK),
        .ROW_W   (ROW_W)
    ) u_pack (
        .clock         (clock),
        .reset         (reset),
        .clear_in      (clear_blk),
        .wr_en_in      (cap_pending_q),
        .wr_row_in     (cap_slot_q),
        .row_data_in   (mem_data_in),
        .lane_valid_in (lane_valid),
        .flat_out      (chunk_flat_out),
        .mask_out      (chunk_mask_out)
    );

    assign mem_read_en_out = read_en;
    assign mem_addr_out    = ADDR_W'(rows_issued_q);
    assign chunk_valid_out = valid;
    assign chunk_last_out  = last;
    assign busy_out        = busy;
    assign done_out        = done_q;

endmodule

// File: doc/sort_chunk_feeder.md
Name: sort_chunk_feeder

Overview:
- Reads a stored stream of tuple pairs from the banked memory, LANES tuples per row, and packs them into CHUNK-wide flat blocks for the bitonic sort stage.
- Replaces the fixed 2-lane, 16-wide hard-wired loader with a parametrised block that has a proper valid/ready handshake, backpressure, a last-chunk flag and partial-chunk handling.
- Sits between the memory instance and the bitonic sorter in the top level.

Parameters:
- TUPLE_W, 128: bit width of one tuple_pair_t.
- LANES, 2: tuples delivered per memory row (even/odd banks = 2). Power of two.
- CHUNK, 16: tuples per output block. Power of two, multiple of LANES, >= LANES.
- ADDR_W, 10: memory row address width.
- LEN_W, 16: width of the tuple count.

Ports:
- clock  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- start_in  in  1  one-cycle pulse; begins a pass. Ignored unless state is IDLE.
- length_in  in  LEN_W  tuple count for the pass; sampled with start_in.
- mem_read_en_out  out  1  memory read strobe.
- mem_addr_out  out  ADDR_W  row address; data returns exactly 1 cycle after the strobe.
- mem_data_in  in  LANES*TUPLE_W  row data; lane 0 in the LSBs (even bank).
- chunk_valid_out  out  1  block available.
- chunk_ready_in  in  1  sorter accepts; a transfer happens when valid and ready are both high.
- chunk_flat_out  out  CHUNK*TUPLE_W  packed block; slot 0 in the LSBs.
- chunk_mask_out  out  CHUNK  1 = slot holds a real tuple.
- chunk_last_out  out  1  qualifies the final block of the pass.
- busy_out  out  1  high from start until done.
- done_out  out  1  one-cycle pulse when the pass completes.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, block register 0.
- Derived quantities:
  - R = CHUNK/LANES reads per block.
  - rows = ceil(length/LANES).
- FSM transitions:
  - IDLE: on start_in with length 0, pulse done_out next cycle and stay IDLE. On start_in with length > 0, latch length, set row pointer to 0 and go to FILL.
  - FILL: issue one read per cycle with consecutive addresses starting at 0, until R reads are issued or rows are exhausted. Capture each returned row one cycle after its read, into slots [k*LANES +: LANES] for the k-th row of the block. After the final capture, go to HOLD.
  - HOLD: chunk_valid_out is high; the block, mask and last flag are stable until transfer. On transfer: if rows remain, clear the block register and return to FILL; otherwise pulse done_out, drop busy_out and go to IDLE.
- Timing:
  - Reads are never issued in HOLD, so backpressure cannot lose in-flight data.
  - With start at cycle 0: reads in cycles 1..R, captures in cycles 2..R+1, valid from cycle R+2.
- Masking and last flag:
  - The mask bit for a tuple is set only if its global index < length. For an odd length with LANES=2, the odd lane of the final row is masked off.
  - chunk_last_out = (rows issued == rows) while in HOLD.
- Address wrap: reaching 2^ADDR_W rows is a caller error. The address wraps modulo 2^ADDR_W and is not flagged.
- Reset mid-pass: return to IDLE immediately, discard the pending capture, done_out is not pulsed.
- start_in while busy is ignored.

Optional Feature:
- Macro FEEDER_PAD_EN.
- Defined: every slot with mask 0 is driven all-ones (max-key sentinel), so padding sorts to the top of ascending order.
- Undefined: unmasked slots are '0, and the consumer must use chunk_mask_out.
- chunk_mask_out exists in both builds.

Decomposition:
- Shared package (extend aoc5.svh): tuple_pair_t, TUPLE_W, default CHUNK/LANES, the feeder state enum {IDLE, FILL, HOLD}, and the flat-index helper macro for slot k.
- Natural sub-module: chunk_pack_reg. It holds the CHUNK-slot register with per-row write enable, clear, mask generation and optional padding.
- Feeder FSM and address/counter logic stay in sort_chunk_feeder.

Test Plan:
- Load 16 tuples (values 0..15), CHUNK=16, LANES=2, ready held high, start at cycle 0 -> reads at addresses 0..7 in cycles 1..8; valid at cycle 10 with slots 0..15 = tuples 0..15, mask 0xFFFF, last=1; done at cycle 11.
- Load 40 tuples -> three blocks; masks 0xFFFF, 0xFFFF, 0x00FF; last only on block 3; rows read 0..19, no address repeated or skipped.
- Load 5 tuples -> one block with mask 0x001F (odd lane of row 2 masked). With FEEDER_PAD_EN, slots 5..15 all-ones; without it, slots 5..15 are 0.
- Hold ready low for 20 cycles in HOLD -> no mem_read_en_out, outputs stable; the transfer happens on the cycle ready rises.
- start_in with length 0 -> done pulse next cycle, no reads, no valid. A second start_in during a 40-tuple pass is ignored.
- Assert reset during FILL (cycle 4) -> all outputs 0 next cycle, no done pulse; a fresh start then reads from row 0.
